dkong_wav_rom_arb: RTL
======================

DKONG_WAV_ROM_ARB -- requirements
Module: dkong_wav_rom_arb

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum WAIT cycles before forced completion (legal range 1..255).
REQ-002 Parameter: SILENCE, default 8'h80, data returned on timeout (unsigned PCM midpoint).
REQ-003 I_CLK  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 I_RST  in  1  asynchronous, active-high reset.
REQ-005 I_REQ  in  3  per-requester request level; bit0 = walk/jump player, bit1 = roar, bit2 = spare.
REQ-006 I_ADDR0, I_ADDR1, I_ADDR2  in  19 each  byte address for the matching requester.
REQ-007 O_ACK  out  3  one-hot, one-cycle pulse; O_DATA is valid for the acked requester.
REQ-008 O_DATA  out  8  returned sample byte.
REQ-009 O_TMO  out  1  one-cycle pulse coincident with an ACK produced by timeout.
REQ-010 O_ROM_AB  out  19  shared wave-ROM address.
REQ-011 O_ROM_RD  out  1  one-cycle read strobe.
REQ-012 I_ROM_DB  in  8  ROM data.
REQ-013 I_ROM_RDY  in  1  ROM data-valid; sampled only in WAIT.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT and DONE; all outputs SHALL be registered.
REQ-015 IDLE: if any I_REQ bit is high, the block SHALL select a winner, latch its address into O_ROM_AB, assert O_ROM_RD, and go to ISSUE; otherwise it SHALL remain in IDLE.
REQ-016 ISSUE: the block SHALL deassert O_ROM_RD, clear the wait timer, and go to WAIT; O_ROM_RD SHALL be high for exactly one cycle per transaction.
REQ-017 WAIT, I_ROM_RDY=1: O_DATA <= I_ROM_DB, set the winner's O_ACK bit, go to DONE.
REQ-018 WAIT, timer = TIMEOUT-1 with I_ROM_RDY=0: O_DATA <= SILENCE, set the winner's O_ACK bit, set O_TMO, go to DONE.
REQ-019 When I_ROM_RDY and timer expiry coincide, I_ROM_RDY SHALL win and O_TMO SHALL stay 0.
REQ-020 DONE: O_ACK and O_TMO SHALL be cleared and the state SHALL return to IDLE; requests are ignored in DONE, which blocks duplicate grants.
REQ-021 Latency: with I_REQ sampled high at edge N and I_ROM_RDY high during WAIT, O_ACK SHALL be high after edge N+3; back-to-back transactions SHALL occur at most once every 4 cycles.
REQ-022 Fixed priority: bit0 > bit1 > bit2.
REQ-023 If a requester drops I_REQ mid-transaction, the transaction SHALL complete and its ACK SHALL still be pulsed.
REQ-024 Requesters SHALL hold the address stable until ACK; the arbiter SHALL use only the address latched in IDLE.
REQ-025 O_DATA SHALL hold its last value between ACKs.
REQ-026 I_ROM_RDY outside WAIT SHALL be ignored.

Reset
REQ-027 On I_RST the block SHALL go to IDLE with O_ACK=0, O_TMO=0, O_ROM_RD=0, O_ROM_AB=0, O_DATA=SILENCE, timer=0 and round-robin pointer=2.
REQ-028 Reset mid-transaction SHALL abort the transaction with no ACK; the first grant after reset release SHALL follow normal priority.

Configuration
REQ-029 Macro DKONG_WAV_ARB_RR_EN, when defined, SHALL select round-robin arbitration: search starts at (last granted + 1) mod 3, and the pointer updates on each grant.
REQ-030 Without DKONG_WAV_ARB_RR_EN, arbitration SHALL be the fixed priority of REQ-022 and no pointer register SHALL be built.

Structure
REQ-031 Shared package dkong_snd_pkg SHALL hold the FSM state encoding, NUM_REQ=3, ROM_AW=19 and the default SILENCE value.
REQ-032 The winner selection (fixed or round-robin) SHALL be a sub-module dkong_arb_pick (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-033 I_REQ=3'b001, I_ADDR0=19'h11000, I_ROM_RDY high in WAIT, DB=8'h5A -> single RD with AB=19'h11000; O_ACK=3'b001 three edges later; O_DATA=8'h5A.
REQ-034 I_REQ=3'b011 held, fixed mode -> every grant goes to bit0; with the RR macro -> grants alternate 001, 010, 001 (pointer reset=2).
REQ-035 I_ROM_RDY held low -> ACK after ISSUE+15 WAIT cycles with O_DATA=8'h80 and O_TMO=1; RDY and expiry in the same cycle -> O_DATA=DB and O_TMO=0.
REQ-036 I_REQ held high continuously -> exactly one ACK per 4 cycles, with no duplicate ACK in the cycle after ACK.
REQ-037 I_RST pulsed during WAIT -> no ACK; outputs at reset values; a new request is granted normally afterwards.

Source files
------------

// File: rtl/dkong_snd_pkg.sv
// Shared types and constants for the Donkey Kong sound wave-ROM path.
// Also holds index helpers used by the requester arbiter (DKONG_WAV_ARB_RR_EN aware).
package dkong_snd_pkg;

  localparam int         NUM_REQ     = 3;
  localparam int         ROM_AW      = 19;
  localparam logic [7:0] SILENCE_DEF = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // (base + off) mod 3 for base in 0..2 and off in 0..3
  function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    if (oh[1]) return 2'd1;
    if (oh[2]) return 2'd2;
    return 2'd0;
  endfunction

endpackage

// File: rtl/dkong_arb_pick.sv
// Combinational winner selection for the wave-ROM arbiter.
// Fixed priority bit0 > bit1 > bit2 by default; round-robin when DKONG_WAV_ARB_RR_EN is defined.
module dkong_arb_pick
  import dkong_snd_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] gnt
);

`ifdef DKONG_WAV_ARB_RR_EN
  logic [1:0] rr_idx;
  logic       rr_found;

  // Search starts one past the last granted requester and wraps.
  always_comb begin
    gnt      = '0;
    rr_found = 1'b0;
    rr_idx   = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = wrap3(ptr, 2'(k));
      if (!rr_found && req[rr_idx]) begin
        gnt[rr_idx] = 1'b1;
        rr_found    = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    if (req[0])      gnt = 3'b001;
    else if (req[1]) gnt = 3'b010;
    else if (req[2]) gnt = 3'b100;
  end
`endif

endmodule

// File: rtl/dkong_wav_rom_arb.sv
// Three-requester arbiter sharing one wave ROM: IDLE -> ISSUE -> WAIT -> DONE, with read timeout.
// Define DKONG_WAV_ARB_RR_EN to switch from fixed priority to round-robin arbitration.
module dkong_wav_rom_arb
  import dkong_snd_pkg::*;
#(
  parameter int         TIMEOUT = 15,
  parameter logic [7:0] SILENCE = SILENCE_DEF
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  input  logic [NUM_REQ-1:0]  I_REQ,
  input  logic [ROM_AW-1:0]   I_ADDR0,
  input  logic [ROM_AW-1:0]   I_ADDR1,
  input  logic [ROM_AW-1:0]   I_ADDR2,
  output logic [NUM_REQ-1:0]  O_ACK,
  output logic [7:0]          O_DATA,
  output logic                O_TMO,
  output logic [ROM_AW-1:0]   O_ROM_AB,
  output logic                O_ROM_RD,
  input  logic [7:0]          I_ROM_DB,
  input  logic                I_ROM_RDY
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  req_q, req_d;
  logic [NUM_REQ-1:0]  win_q, win_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [ROM_AW-1:0]   ab_q, ab_d;
  logic                rd_q, rd_d;
  logic                tmo_q, tmo_d;
  logic [7:0]          data_q, data_d;
  logic [7:0]          timer_q, timer_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [1:0]          pick_ptr;

`ifdef DKONG_WAV_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = 2'd2;
`endif

  dkong_arb_pick u_pick (
    .req (req_q),
    .ptr (pick_ptr),
    .gnt (gnt)
  );

  always_comb begin
    state_d = state_q;
    req_d   = I_REQ;
    win_d   = win_q;
    ab_d    = ab_q;
    rd_d    = 1'b0;
    ack_d   = '0;
    tmo_d   = 1'b0;
    data_d  = data_q;
    timer_d = timer_q;
`ifdef DKONG_WAV_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|req_q) begin
          win_d = gnt;
          if (gnt[0])      ab_d = I_ADDR0;
          else if (gnt[1]) ab_d = I_ADDR1;
          else             ab_d = I_ADDR2;
          rd_d    = 1'b1;
          state_d = ST_ISSUE;
`ifdef DKONG_WAV_ARB_RR_EN
          ptr_d   = onehot_idx(gnt);
`endif
        end
      end
      ST_ISSUE: begin
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      // ROM ready takes precedence over a timeout landing in the same cycle.
      ST_WAIT: begin
        if (I_ROM_RDY) begin
          data_d  = I_ROM_DB;
          ack_d   = win_q;
          state_d = ST_DONE;
        end else if (timer_q == TMO_LAST) begin
          data_d  = SILENCE;
          ack_d   = win_q;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      win_q   <= '0;
      ab_q    <= '0;
      rd_q    <= 1'b0;
      ack_q   <= '0;
      tmo_q   <= 1'b0;
      data_q  <= SILENCE;
      timer_q <= 8'd0;
`ifdef DKONG_WAV_ARB_RR_EN
      ptr_q   <= 2'd2;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      win_q   <= win_d;
      ab_q    <= ab_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      timer_q <= timer_d;
`ifdef DKONG_WAV_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign O_ACK    = ack_q;
  assign O_TMO    = tmo_q;
  assign O_DATA   = data_q;
  assign O_ROM_AB = ab_q;
  assign O_ROM_RD = rd_q;

endmodule
